// File: rtl/rename_unit_ckpt.sv
// Register rename unit: RAT, circular physical free list and a FIFO of
// branch checkpoints giving single-cycle recovery on a mispredict.
module rename_unit_ckpt #(
  parameter  int ARCH_REGS  = 32,
  parameter  int PHYS_REGS  = 64,
  parameter  int CKPT_DEPTH = 4,
  localparam int AW = $clog2(ARCH_REGS),
  localparam int PW = $clog2(PHYS_REGS),
  localparam int CW = $clog2(CKPT_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ren_valid,
  output logic          ren_ready,
  input  logic [AW-1:0] ren_src1,
  input  logic [AW-1:0] ren_src2,
  input  logic [AW-1:0] ren_dest,
  input  logic          ren_ckpt,
  output logic          out_valid,
  output logic [PW-1:0] out_src1,
  output logic [PW-1:0] out_src2,
  output logic [PW-1:0] out_dest,
  output logic [PW-1:0] out_dest_old,
  output logic [CW-1:0] out_ckpt_id,
  input  logic          commit_valid,
  input  logic [PW-1:0] commit_free,
  input  logic          release_valid,
  input  logic          recover_valid,
  input  logic [CW-1:0] recover_id,
  output logic [PW:0]   free_count
);

  localparam logic [PW:0] FREE_MAX = (PW+1)'(PHYS_REGS - ARCH_REGS);
  localparam logic [CW:0] CK_FULL  = (CW+1)'(CKPT_DEPTH);

  logic [ARCH_REGS-1:0][PW-1:0] map_q, map_d;
  logic [PHYS_REGS-1:0][PW-1:0] fl_q, fl_d;
  logic [PW:0] head_q, head_d, tail_q, tail_d;

  logic [CKPT_DEPTH-1:0][ARCH_REGS-1:0][PW-1:0] ck_map_q, ck_map_d;
  logic [CKPT_DEPTH-1:0][PW:0] ck_fh_q, ck_fh_d;
  logic [CW:0] ck_head_q, ck_head_d, ck_tail_q, ck_tail_d, ck_cnt;

  logic          out_valid_q, out_valid_d;
  logic [PW-1:0] out_src1_q, out_src1_d, out_src2_q, out_src2_d;
  logic [PW-1:0] out_dest_q, out_dest_d, out_old_q, out_old_d;
  logic [CW-1:0] out_ck_q, out_ck_d;

  logic xfer, alloc, push, rel;

  assign free_count = tail_q - head_q;
  assign ck_cnt     = ck_tail_q - ck_head_q;
  assign ren_ready  = !recover_valid && (free_count != '0)
                      && !(ren_ckpt && (ck_cnt == CK_FULL));
  assign xfer  = ren_valid && ren_ready;
  assign alloc = xfer && (ren_dest != '0);
  assign push  = commit_valid && (commit_free != '0);
  assign rel   = release_valid && (ck_cnt != '0);

  assign out_valid    = out_valid_q;
  assign out_src1     = out_src1_q;
  assign out_src2     = out_src2_q;
  assign out_dest     = out_dest_q;
  assign out_dest_old = out_old_q;
  assign out_ckpt_id  = out_ck_q;

  always_comb begin
    map_d       = map_q;
    fl_d        = fl_q;
    head_d      = head_q;
    tail_d      = tail_q;
    ck_map_d    = ck_map_q;
    ck_fh_d     = ck_fh_q;
    ck_head_d   = ck_head_q;
    ck_tail_d   = ck_tail_q;
    out_valid_d = xfer;
    out_src1_d  = out_src1_q;
    out_src2_d  = out_src2_q;
    out_dest_d  = out_dest_q;
    out_old_d   = out_old_q;
    out_ck_d    = out_ck_q;

    if (push) begin
      fl_d[tail_q[PW-1:0]] = commit_free;
      tail_d = tail_q + 1'b1;
    end
    if (rel) ck_head_d = ck_head_q + 1'b1;

    // Truncation is applied after any same-cycle release.
    if (recover_valid) begin
      map_d     = ck_map_q[recover_id];
      head_d    = ck_fh_q[recover_id];
      ck_tail_d = ck_head_d + {1'b0, recover_id - ck_head_d[CW-1:0]};
    end else if (xfer) begin
      out_src1_d = map_q[ren_src1];
      out_src2_d = map_q[ren_src2];
      out_dest_d = '0;
      out_old_d  = '0;
      out_ck_d   = '0;
      if (alloc) begin
        out_dest_d       = fl_q[head_q[PW-1:0]];
        out_old_d        = map_q[ren_dest];
        map_d[ren_dest]  = out_dest_d;
        head_d           = head_q + 1'b1;
      end
      if (ren_ckpt) begin
        ck_map_d[ck_tail_q[CW-1:0]] = map_d;
        ck_fh_d[ck_tail_q[CW-1:0]]  = head_d;
        out_ck_d  = ck_tail_q[CW-1:0];
        ck_tail_d = ck_tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
      for (int i = 0; i < PHYS_REGS; i++) fl_q[i] <= PW'(i + ARCH_REGS);
      head_q      <= '0;
      tail_q      <= FREE_MAX;
      ck_map_q    <= '0;
      ck_fh_q     <= '0;
      ck_head_q   <= '0;
      ck_tail_q   <= '0;
      out_valid_q <= 1'b0;
      out_src1_q  <= '0;
      out_src2_q  <= '0;
      out_dest_q  <= '0;
      out_old_q   <= '0;
      out_ck_q    <= '0;
    end else begin
      map_q       <= map_d;
      fl_q        <= fl_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      ck_map_q    <= ck_map_d;
      ck_fh_q     <= ck_fh_d;
      ck_head_q   <= ck_head_d;
      ck_tail_q   <= ck_tail_d;
      out_valid_q <= out_valid_d;
      out_src1_q  <= out_src1_d;
      out_src2_q  <= out_src2_d;
      out_dest_q  <= out_dest_d;
      out_old_q   <= out_old_d;
      out_ck_q    <= out_ck_d;
    end
  end

  logic [PHYS_REGS-1:0] in_win;
  logic                 fl_dup;

  // Only the live window head..tail-1 of the free list is meaningful.
  always_comb begin
    fl_dup = 1'b0;
    for (int i = 0; i < PHYS_REGS; i++)
      in_win[i] = {1'b0, PW'(i) - head_q[PW-1:0]} < free_count;
    for (int i = 0; i < PHYS_REGS; i++)
      for (int j = i + 1; j < PHYS_REGS; j++)
        if (in_win[i] && in_win[j] && (fl_q[i] == fl_q[j]))
          fl_dup = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (free_count <= FREE_MAX)
        else $error("free_count above capacity");
      assert (!fl_dup)
        else $error("physical register twice in free list");
    end
  end

endmodule

// File: doc/rename_unit_ckpt.md
Name: rename_unit_ckpt

Overview:
- Parametrised register-rename unit: combined RAT, circular physical free list, and a FIFO of branch checkpoints for single-cycle mispredict recovery.
- Sits between decode and dispatch/ROB.
- Renames one instruction per cycle with a valid/ready handshake.
- Takes freed registers back from ROB commit.

Parameters:
- ARCH_REGS, 32, architectural registers; register 0 is hard-wired and never renamed.
- PHYS_REGS, 64, physical registers; power of two, greater than ARCH_REGS.
- CKPT_DEPTH, 4, checkpoint slots; power of two.
- Derived: AW = clog2(ARCH_REGS), PW = clog2(PHYS_REGS), CW = clog2(CKPT_DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high.
- ren_valid  in  1  decode presents an instruction.
- ren_ready  out  1  unit accepts; a transfer is ren_valid & ren_ready.
- ren_src1, ren_src2, ren_dest  in  AW each  architectural operands.
- ren_ckpt  in  1  instruction is a branch; take a checkpoint.
- out_valid  out  1  registered rename result valid.
- out_src1, out_src2, out_dest, out_dest_old  out  PW each  physical mapping; out_dest_old is the previous mapping of ren_dest.
- out_ckpt_id  out  CW  checkpoint id given to the branch; 0 when none.
- commit_valid  in  1  ROB retires an instruction.
- commit_free  in  PW  physical register to free (the dest_old of the retiring instruction).
- release_valid  in  1  oldest branch resolved correct; free its checkpoint.
- recover_valid  in  1  mispredict.
- recover_id  in  CW  checkpoint to restore.
- free_count  out  PW+1  number of free physical registers.

Behaviour:
- Reset, asynchronous and applied immediately:
  - map[i] = i.
  - Free list holds ARCH_REGS..PHYS_REGS-1 in order; head = 0, tail = PHYS_REGS-ARCH_REGS (pointers carry PW+1 bits, including a wrap bit).
  - free_count = PHYS_REGS-ARCH_REGS.
  - Checkpoint FIFO is empty.
  - out_valid = 0; all out_* = 0.
  - ren_ready follows the combinational rule below from the reset state.
- ren_ready = !recover_valid & (free_count != 0) & !(ren_ckpt & ckpt_full).
  - ren_ready is computed from registered state only; commit_free is not bypassed into allocation.
- On a transfer, the outputs below are registered and appear with out_valid = 1 on the next cycle. With no transfer, out_valid = 0 next cycle and the other out_* hold their values.
  - out_src1/out_src2 = map[src] before this instruction's update.
  - If ren_dest != 0: out_dest = freelist[head]; out_dest_old = map[dest]; map[dest] <= out_dest; head++.
  - If ren_dest == 0: out_dest = out_dest_old = 0; no allocation.
- Checkpoints:
  - When ren_ckpt is set on a transfer, checkpoint slot ckpt_tail stores the post-update map and the post-update head.
  - out_ckpt_id = ckpt_tail; ckpt_tail++.
  - ckpt_full when CKPT_DEPTH slots are in use.
- Commit:
  - commit_valid with commit_free != 0: freelist[tail] <= commit_free; tail++.
  - commit_free == 0 is ignored.
- release_valid pops the oldest checkpoint (ckpt_head++). Branches resolve in order; release with the FIFO empty is ignored.
- Recover:
  - recover_valid: map <= slot[recover_id].map; head <= slot[recover_id].head.
  - The checkpoint FIFO is truncated so that recover_id and all younger slots are freed: ckpt_tail <= recover_id.
  - No rename occurs that cycle. out_valid = 0 next cycle.
- free_count = tail - head, using full pointer width; range 0..PHYS_REGS-ARCH_REGS.
- Simultaneous events in one cycle:
  - Commit + rename: both are applied; the commit push does not feed that cycle's allocation.
  - Commit + recover: the commit is applied; tail is unaffected by recovery.
  - Release + recover in the same cycle: release is applied first, then truncation. Recovering the released id is illegal.
- Wrap-around: head and tail wrap modulo PHYS_REGS; the wrap bit distinguishes full from empty.
- Assertions:
  - free_count never exceeds PHYS_REGS-ARCH_REGS.
  - No physical register is present twice in the free list.

Test Plan:
- Reset, then rename r1<-r2,r3 -> next cycle out_valid=1, src1=2, src2=3, dest=32, dest_old=1, free_count=31.
- Rename dest=r0 -> out_dest=0, out_dest_old=0, free_count unchanged.
- 32 back-to-back renames with no commits -> free_count=0, ren_ready=0. One commit of p5 -> free_count=1 next cycle; the following rename gets dest=5.
- Branch with ckpt (id 0), then rename r1->p33 and r2->p34, then recover_id=0 -> next cycle map[1]=32, free_count=31, next rename of r7 gets p33.
- Four outstanding branch checkpoints with a fifth branch pending -> ren_ready=0. release_valid -> ren_ready=1 and the fifth branch gets id 0 (wrap).
- Assert reset during a rename burst -> out_valid=0 immediately, map identity, free_count=32 on deassertion.
